// File: rtl/wb_pkg.sv
// Purpose: shared types and constants for the writeback unit and its load-result buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    localparam int WB_DEFAULT_DEPTH = 2;

    // One pending register-file write: destination register and its data.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // Register x0 is hardwired to zero, so results aimed at it are never written.
    function automatic logic rd_writes(input logic [4:0] rd);
        return rd != 5'd0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Purpose: small circular buffer of load results waiting for a free writeback slot.
// Latency: push visible at the head the cycle after it is written; pop consumes the head at the edge.
// Backpressure: full/empty exported; push while full and pop while empty are ignored.
//
// Ports: clk, reset (async, active-high); push/push_dat write the tail;
//        pop removes the head shown on pop_dat; full, empty, count report occupancy.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                push_dat,
    input  logic                     pop,
    output wb_entry_t                pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    wb_entry_t     mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Purpose: arbitrates ALU and load results onto the single register-file write port.
// Latency: 1 cycle for the ALU and for a load taken directly; other loads wait in the buffer.
// Backpressure: ld_ready drops when the buffer is full; alu_stall rises at the same time so the buffer drains.
//
// Ports: clk, reset (async, active-high); alu_valid/alu_rd/alu_result in, alu_stall out;
//        ld_valid/ld_rd/ld_data in, ld_ready out; A3/WD3/RegWrite registered write port;
//        fifo_count buffer occupancy.
// Optional: define WB_FWD_EN to add fwd_rs1/fwd_rs2 inputs and fwd1/fwd2 hit/data outputs
//        that forward the write currently on the port.
// FIFO_DEPTH must be a power of two and at least 2.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [31:0]                   alu_result,
    output logic                          alu_stall,
    input  logic                          ld_valid,
    input  logic [4:0]                    ld_rd,
    input  logic [31:0]                   ld_data,
    output logic                          ld_ready,
    output logic [4:0]                    A3,
    output logic [31:0]                   WD3,
    output logic                          RegWrite,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]                    fwd_rs1,
    input  logic [4:0]                    fwd_rs2,
    output logic                          fwd1_hit,
    output logic                          fwd2_hit,
    output logic [31:0]                   fwd1_data,
    output logic [31:0]                   fwd2_data
`endif
);

    wb_entry_t head;
    wb_entry_t ld_entry;
    wb_entry_t sel_entry;
    logic      sel_vld;
    logic      full;
    logic      empty;
    logic      alu_sel;
    logic      fifo_sel;
    logic      ld_acc;
    logic      ld_direct;
    logic      push;

    assign ld_entry = '{rd: ld_rd, data: ld_data};

    // Occupancy is already zero during reset; gating with reset keeps both
    // handshake outputs quiet for the whole reset window.
    assign ld_ready  = !reset && !full;
    assign alu_stall = !reset && full;

    // Fixed priority: ALU, then buffered loads (to keep load order), then a
    // fresh load straight through when nothing is queued ahead of it.
    assign alu_sel   = alu_valid && !alu_stall;
    assign fifo_sel  = !alu_sel && !empty;
    assign ld_acc    = ld_valid && ld_ready;
    assign ld_direct = !alu_sel && empty && ld_acc;

    // Accepted loads to x0 are dropped here rather than occupying a slot.
    // A push never coincides with full because ld_ready is low then.
    assign push = ld_acc && !ld_direct && rd_writes(ld_rd);

    wb_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (ld_entry),
        .pop      (fifo_sel),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    always_comb begin
        sel_vld   = 1'b0;
        sel_entry = '0;
        if (alu_sel) begin
            sel_vld   = 1'b1;
            sel_entry = '{rd: alu_rd, data: alu_result};
        end else if (fifo_sel) begin
            sel_vld   = 1'b1;
            sel_entry = head;
        end else if (ld_direct) begin
            sel_vld   = 1'b1;
            sel_entry = ld_entry;
        end
    end

    // A3/WD3 only change on a real write; x0 results are consumed silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
        end else if (sel_vld && rd_writes(sel_entry.rd)) begin
            RegWrite <= 1'b1;
            A3       <= sel_entry.rd;
            WD3      <= sel_entry.data;
        end else begin
            RegWrite <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    assign fwd1_hit  = RegWrite && (A3 == fwd_rs1) && (fwd_rs1 != 5'd0);
    assign fwd2_hit  = RegWrite && (A3 == fwd_rs2) && (fwd_rs2 != 5'd0);
    assign fwd1_data = WD3;
    assign fwd2_data = WD3;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Purpose: self-checking bench for writeback_unit (directed scenarios plus random traffic).
// Latency: n/a.
// Backpressure: held loads are re-offered until the reference model accepts them.
module tb_writeback_unit;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_result;
    logic          alu_stall;
    logic          ld_valid;
    logic [4:0]    ld_rd;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic [4:0]    A3;
    logic [31:0]   WD3;
    logic          RegWrite;
    logic [CW-1:0] fifo_count;
`ifdef WB_FWD_EN
    logic [4:0]    fwd_rs1;
    logic [4:0]    fwd_rs2;
    logic          fwd1_hit;
    logic          fwd2_hit;
    logic [31:0]   fwd1_data;
    logic [31:0]   fwd2_data;
`endif

    always #5 clk = ~clk;

    writeback_unit #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_result (alu_result),
        .alu_stall  (alu_stall),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .A3         (A3),
        .WD3        (WD3),
        .RegWrite   (RegWrite),
        .fifo_count (fifo_count)
`ifdef WB_FWD_EN
        ,
        .fwd_rs1    (fwd_rs1),
        .fwd_rs2    (fwd_rs2),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: a queue of pending loads plus the last write seen on the port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_a3 = '0;
    logic [31:0] m_wd = '0;

    task automatic model_reset();
        q.delete();
        m_we = 1'b0;
        m_a3 = '0;
        m_wd = '0;
    endtask

    task automatic check_outs();
        logic busy_full;
        busy_full = (q.size() == DEPTH);
        chk("RegWrite",   32'(RegWrite),   32'(m_we));
        chk("A3",         32'(A3),         32'(m_a3));
        chk("WD3",        WD3,             m_wd);
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("ld_ready",   32'(ld_ready),   32'(!reset && !busy_full));
        chk("alu_stall",  32'(alu_stall),  32'(!reset && busy_full));
`ifdef WB_FWD_EN
        chk("fwd1_hit",  32'(fwd1_hit), 32'(m_we && m_a3 == fwd_rs1 && fwd_rs1 != 0));
        chk("fwd2_hit",  32'(fwd2_hit), 32'(m_we && m_a3 == fwd_rs2 && fwd_rs2 != 0));
        chk("fwd1_data", fwd1_data, m_wd);
        chk("fwd2_data", fwd2_data, m_wd);
`endif
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge(output logic acc);
        logic rdy;
        logic stall;
        logic have;
        logic took_ld;
        ent_t s;
        rdy     = (q.size() < DEPTH);
        stall   = (q.size() == DEPTH);
        have    = 1'b0;
        took_ld = 1'b0;
        s.rd    = '0;
        s.data  = '0;
        if (alu_valid && !stall) begin
            s.rd = alu_rd; s.data = alu_result; have = 1'b1;
        end else if (q.size() != 0) begin
            s = q.pop_front(); have = 1'b1;
        end else if (ld_valid && rdy) begin
            s.rd = ld_rd; s.data = ld_data; have = 1'b1; took_ld = 1'b1;
        end
        if (ld_valid && rdy && !took_ld && ld_rd != 0) q.push_back('{ld_rd, ld_data});
        acc = ld_valid && rdy;
        if (have && s.rd != 0) begin
            m_we = 1'b1; m_a3 = s.rd; m_wd = s.data;
        end else begin
            m_we = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, check the pre-edge state, step the model, pass the edge.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         output logic acc);
        alu_valid  = av;
        alu_rd     = ard;
        alu_result = ares;
        ld_valid   = lv;
        ld_rd      = lrd;
        ld_data    = ldat;
        #1;
        check_outs();
        model_edge(acc);
        @(posedge clk);
        #1;
    endtask

    logic        acc;
    int          k;
    logic        lv_r;
    logic [4:0]  lrd_r;
    logic [31:0] ld_r;

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data    = '0;
`ifdef WB_FWD_EN
        fwd_rs1 = '0; fwd_rs2 = '0;
`endif
        model_reset();
        #1;
        check_outs();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outs();
        reset = 1'b0;

        // ALU only.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, acc);
        chk("alu_only.RegWrite", 32'(RegWrite), 32'd1);
        chk("alu_only.A3",       32'(A3),       32'd5);
        chk("alu_only.WD3",      WD3,           32'hDEADBEEF);

        // x0 filter on both sources.
        cycle(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678, acc);
        chk("x0.RegWrite",   32'(RegWrite),   32'd0);
        chk("x0.fifo_count", 32'(fifo_count), 32'd0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h9999, acc);
        chk("x0_ld.RegWrite", 32'(RegWrite), 32'd0);

        // Conflict: ALU first, load queued, then load one cycle later.
        cycle(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd7, 32'h11, acc);
        chk("conflict.A3",         32'(A3),         32'd3);
        chk("conflict.fifo_count", 32'(fifo_count), 32'd1);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);
        chk("conflict.A3_ld",  32'(A3), 32'd7);
        chk("conflict.WD3_ld", WD3,     32'h11);
        chk("conflict.drain",  32'(fifo_count), 32'd0);

        // Backpressure: continuous ALU traffic plus three loads.
        k = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 5'(20 + i), 32'hA000_0000 + i, (k < 3), 5'(10 + k), 32'hB000_0000 + k, acc);
            if (acc) k++;
            if (i == 1) begin
                chk("bp.fifo_count", 32'(fifo_count), 32'd2);
                chk("bp.ld_ready",   32'(ld_ready),   32'd0);
                chk("bp.alu_stall",  32'(alu_stall),  32'd1);
            end
        end
        chk("bp.loads_accepted", 32'(k), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);
        chk("bp.empty", 32'(fifo_count), 32'd0);

        // Async reset with two queued entries.
        cycle(1'b1, 5'd1, 32'hC1, 1'b1, 5'd13, 32'hD13, acc);
        cycle(1'b1, 5'd2, 32'hC2, 1'b1, 5'd14, 32'hD14, acc);
        chk("rst.pre_count", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst.RegWrite",   32'(RegWrite),   32'd0);
        chk("rst.fifo_count", 32'(fifo_count), 32'd0);
        check_outs();
        @(posedge clk);
        #1;
        check_outs();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);
        chk("rst.no_late_write", 32'(RegWrite), 32'd0);

`ifdef WB_FWD_EN
        fwd_rs1 = 5'd9;
        fwd_rs2 = 5'd0;
        cycle(1'b1, 5'd9, 32'h0000_0999, 1'b0, 5'd0, 32'h0, acc);
        chk("fwd.fwd1_hit",  32'(fwd1_hit), 32'd1);
        chk("fwd.fwd1_data", fwd1_data,     32'h0000_0999);
        chk("fwd.fwd2_hit",  32'(fwd2_hit), 32'd0);
`endif

        // Random traffic; a refused load is re-offered unchanged.
        lv_r = 1'b0; lrd_r = '0; ld_r = '0;
        for (int i = 0; i < 500; i++) begin
            if (!lv_r) begin
                lv_r  = ($urandom_range(0, 99) < 55);
                lrd_r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ld_r  = $urandom;
            end
`ifdef WB_FWD_EN
            fwd_rs1 = 5'($urandom_range(0, 31));
            fwd_rs2 = ($urandom_range(0, 1) == 1) ? A3 : 5'($urandom_range(0, 31));
`endif
            cycle(($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom, lv_r, lrd_r, ld_r, acc);
            if (acc) lv_r = 1'b0;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc);
        chk("final.fifo_count", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, load-result buffer entries; power of two, at least 2.
REQ-002 SHALL have ports, in order:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- alu_valid, input, 1, ALU result present this cycle.
- alu_rd, input, 5, ALU destination register.
- alu_result, input, 32, ALU write data.
- alu_stall, output, 1, upstream ALU path must hold.
- ld_valid, input, 1, load result offered.
- ld_rd, input, 5, load destination register.
- ld_data, input, 32, load write data.
- ld_ready, output, 1, load result accepted when high with ld_valid.
- A3, output, 5, register-file write address.
- WD3, output, 32, register-file write data.
- RegWrite, output, 1, register-file write enable.
- fifo_count, output, $clog2(FIFO_DEPTH)+1, occupied entries.
REQ-003 Clocking is decided: one clock; reset is asynchronous and active-high; ports named clk and reset.

Function
REQ-004 A3, WD3 and RegWrite SHALL be registered; at most one write per cycle.
REQ-005 Source priority at each edge SHALL be:
- if alu_stall is low and alu_valid: ALU;
- else if FIFO non-empty: FIFO head, popped;
- else if ld_valid and ld_ready: load input directly, FIFO bypassed;
- else: RegWrite <= 0, A3 and WD3 hold.
REQ-006 RegWrite SHALL be 1 only when the selected rd is nonzero; rd=0 results are consumed but never written.
REQ-007 Latency SHALL be 1 cycle for the ALU, and 1 cycle for a load only when it is taken directly under REQ-005; otherwise the load is enqueued.
REQ-008 A load SHALL be enqueued when ld_valid and ld_ready and it is not the direct source; loads with ld_rd=0 SHALL be accepted and dropped, not enqueued.
REQ-009 ld_ready SHALL equal (fifo_count < FIFO_DEPTH) and not reset; pop and push in the same cycle when full SHALL NOT be allowed.
REQ-010 alu_stall SHALL be combinational, high when fifo_count == FIFO_DEPTH; while high, alu_valid is ignored and the FIFO head drains.
REQ-011 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 Load results SHALL be written in acceptance order; the ALU MAY overtake queued loads.

Reset
REQ-013 While reset is high, outputs SHALL be:
- RegWrite=0, A3=0, WD3=0;
- fifo_count=0, pointers=0;
- ld_ready=0, alu_stall=0.
REQ-014 Reset asserted mid-operation SHALL discard queued entries with no partial write.

Configuration
REQ-015 With macro WB_FWD_EN defined, writeback_unit SHALL add the following ports:
- inputs fwd_rs1[4:0] and fwd_rs2[4:0];
- outputs fwd1_hit, fwd2_hit, fwd1_data[31:0], fwd2_data[31:0].
REQ-016 With WB_FWD_EN defined, forwarding SHALL be combinational:
- fwdN_hit = RegWrite && (A3 == fwd_rsN) && (fwd_rsN != 0);
- fwdN_data = WD3.
REQ-017 Without WB_FWD_EN, those ports and that logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-018 Package wb_pkg SHALL hold typedef wb_entry_t {rd[4:0], data[31:0]} and constant WB_DEFAULT_DEPTH=2.
REQ-019 Buffering SHALL be a sub-module wb_fifo with push/pop/full/empty/count; writeback_unit holds arbitration and output registers.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ALU only: alu_valid, rd=5, result=0xDEADBEEF -> next cycle A3=5, WD3=0xDEADBEEF, RegWrite=1.
- x0 filter: ALU rd=0 and load rd=0 -> RegWrite stays 0; fifo_count stays 0.
- Conflict: ALU rd=3 and load rd=7 (0x11) in the same cycle -> the ALU writes first, the load is enqueued (fifo_count=1), then A3=7, WD3=0x11 one cycle later.
- Backpressure: continuous ALU traffic plus 3 loads with FIFO_DEPTH=2 -> fifo_count reaches 2, ld_ready=0, alu_stall=1, then the queue drains in order 2 cycles later.
- Async reset with 2 queued entries -> immediate RegWrite=0, fifo_count=0, and no later write of discarded data.
- WB_FWD_EN: RegWrite=1, A3=9, fwd_rs1=9, fwd_rs2=0 -> fwd1_hit=1, fwd1_data=WD3, fwd2_hit=0.
